mult_seq_hilo: RTL and testbench
================================

Name: mult_seq_hilo

Overview:
- Iterative radix-2 shift-add 32x32 multiplier with architectural HI/LO registers for the MIPS core.
- Sits downstream of the execute stage: accepts MULT/MULTU operands, writes the 64-bit product into HI (upper) and LO (lower).
- Services MTHI/MTLO writes and MFHI/MFLO reads.
- Raises a pipeline stall while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, product is 2*WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  MULT/MULTU issue strobe, sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- op_a  input  WIDTH  multiplier.
- op_b  input  WIDTH  multiplicand.
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- hilo_access  input  1  decode stage holds MFHI/MFLO/MTHI/MTLO.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse when HI/LO hold a new product.
- stall  output  1  combinational: busy & hilo_access.
- hi  output  WIDTH  HI register (product upper half).
- lo  output  WIDTH  LO register (product lower half).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0; internal accumulator, counter and sign flag = 0. Reset mid-operation aborts the multiply; HI/LO read 0 afterwards.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1 at edge E0:
  - If is_signed, latch |op_a|, |op_b| and neg = op_a[MSB]^op_b[MSB]; else latch raw operands with neg=0.
  - Clear the 2*WIDTH accumulator; counter=0; busy=1 from the cycle after E0; go to CALC.
- CALC, one iteration per edge:
  - If the multiplier LSB = 1, add the multiplicand into the upper half of the accumulator, using a WIDTH+1-bit carry.
  - Shift accumulator/multiplier right by 1; counter++.
  - After WIDTH iterations (edges E1..E32 for WIDTH=32) go to FIX.
- FIX (edge E33):
  - Product = neg ? two's-complement negate of the 2*WIDTH accumulator : accumulator.
  - hi = product[2W-1:W], lo = product[W-1:0].
  - done=1 and busy=0 for the cycle following E33; return to IDLE.
  - Total: HI/LO valid WIDTH+2 edges after start is sampled.
- Signed edge case: most-negative operand (0x80000000) has magnitude 2^31, which must be represented unsigned (no overflow).
- start while busy: ignored, with no effect on the running operation.
- mthi/mtlo, effective only when busy=0:
  - While busy they are ignored; the pipeline must hold them via stall.
  - mthi and mtlo together write both registers.
- start plus mthi/mtlo in the same IDLE cycle: both take effect; the move updates HI/LO now, and the product overwrites them at FIX.
- Outputs hi/lo always show the register contents. During CALC they hold the previous values; partial results are never exposed.
- done is a registered pulse, exactly 1 cycle, and never asserted in the same cycle as busy.

Decomposition:
- Package mult_pkg holds:
  - state enum {IDLE, CALC, FIX};
  - localparam CNT_W = $clog2(WIDTH+1);
  - a reset-value constant for HI/LO.
- One natural sub-module, mult_shift_add_core: unsigned iterative core (accumulator, counter, add/shift) with a load/step/last interface.
- The top level owns sign handling, FIX negation, HI/LO registers, MTHI/MTLO and stall.

Test Plan:
- Unsigned: op_a=0x80000000, op_b=2, is_signed=0, start -> after 34 edges hi=0x00000001, lo=0x00000000, single done pulse; busy high for exactly 33 cycles.
- Signed: op_a=0x80000000, op_b=2, is_signed=1 -> hi=0xFFFFFFFF, lo=0x00000000. Then op_a=op_b=0xFFFFFFFF signed -> hi=0, lo=1; unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
- Busy interlock:
  - During CALC, assert hilo_access -> stall=1; drop it -> stall=0.
  - A second start at cycle 5 of CALC is ignored; the result matches the first operands.
  - mthi with wdata=0xDEADBEEF during CALC is ignored.
- Moves in IDLE: mthi wdata=0x12345678, then mtlo wdata=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0; neither raises busy nor done.
- Simultaneous: mtlo wdata=0x55 with start (op_a=3, op_b=5, unsigned) -> lo=0x55 next cycle, then hi=0, lo=15 after FIX.
- Reset mid-op: start 7*9, drop rst_n at cycle 10 of CALC -> immediately busy=0, done=0, hi=lo=0. After release, a new start 7*9 -> lo=63.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential HI/LO multiplier.
//   state_t   : top-level sequencing states IDLE -> CALC -> FIX -> IDLE
//   CNT_W     : iteration counter width for the default operand width
//   HILO_RST  : value HI/LO take on reset
package mult_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W     = $clog2(WIDTH_DEF + 1);

    localparam logic [WIDTH_DEF-1:0] HILO_RST = '0;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

endpackage

// File: rtl/mult_seq_hilo_if.sv
// Pipeline-side bundle for the sequential multiplier / HI-LO unit.
//   master : pipeline (drives start/operands/moves, observes status and HI/LO)
//   slave  : multiplier unit
// Signals:
//   start, is_signed, op_a, op_b : MULT/MULTU issue
//   mthi, mtlo, wdata            : HI/LO moves
//   hilo_access                  : decode holds an HI/LO instruction
//   busy, done, stall            : status back to the pipeline
//   hi, lo                       : architectural HI/LO contents
interface mult_seq_hilo_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             hilo_access;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b, mthi, mtlo, wdata, hilo_access,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b, mthi, mtlo, wdata, hilo_access,
        output busy, done, stall, hi, lo
    );

endinterface

// File: rtl/mult_shift_add_core.sv
// Unsigned radix-2 shift-add multiplier datapath.
//   clk, rst_n     : clock, asynchronous active-low reset
//   load           : capture mplier/mcand, clear accumulator and counter
//   step           : perform one add/shift iteration
//   mplier, mcand  : unsigned operands (multiplier, multiplicand)
//   acc            : 2*WIDTH accumulator; holds the product after WIDTH steps
//   last           : high during the step that completes the final iteration
module mult_shift_add_core
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     sum;

    always_comb begin
        // Add into the upper half with one extra carry bit, then shift the
        // whole accumulator right so the carry lands in the top bit.
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (mplier_q[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
        acc_d = {sum, acc_q[WIDTH-1:1]};
        last  = step && (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            acc_q    <= '0;
            mplier_q <= mplier;
            mcand_q  <= mcand;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mult_seq_hilo.sv
// Iterative 32x32 MULT/MULTU unit with architectural HI/LO registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mult_seq_hilo_if (issue, moves, status, HI/LO)
// A multiply takes WIDTH+2 edges from the sampled start to HI/LO update.
// Signed operands are reduced to magnitudes; the sign is reapplied in FIX.
module mult_seq_hilo
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input logic            clk,
    input logic            rst_n,
    mult_seq_hilo_if.slave bus
);

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               neg_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               load;
    logic               step;
    logic               last;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        load  = (state_q == IDLE) && bus.start;
        step  = (state_q == CALC);
        // The most negative value negates to itself, which read as unsigned
        // is exactly its magnitude 2^(WIDTH-1).
        a_mag = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
        b_mag = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
        prod  = neg_q ? -acc : acc;
    end

    mult_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .mplier (a_mag),
        .mcand  (b_mag),
        .acc    (acc),
        .last   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            hi_q    <= WIDTH'(HILO_RST);
            lo_q    <= WIDTH'(HILO_RST);
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Moves apply even alongside start; FIX overwrites later.
                    if (!busy_q) begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                    if (bus.start) begin
                        neg_q   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (last) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= prod[2*WIDTH-1:WIDTH];
                    lo_q    <= prod[WIDTH-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    neg_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & bus.hilo_access;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mult_seq_hilo.sv
// Self-checking bench for mult_seq_hilo: scoreboard of expected products
// popped whenever done pulses, plus directed checks on HI/LO, busy, stall.
module tb_mult_seq_hilo;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mult_seq_hilo_if #(.WIDTH(32)) bus ();

    mult_seq_hilo #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] sb_exp;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          nb;
    int          nc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        if (s) return sa * sb;
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit push);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.is_signed = s;
        bus.start     = 1'b1;
        if (push) sb_q.push_back(model(a, b, s));
        next_drive();
        bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is seen.
    task automatic wait_result(output int nbusy, output int ncyc);
        nbusy = 0;
        ncyc  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ncyc++;
            if (bus.done) break;
            if (bus.busy) nbusy++;
        end
        if (!bus.done) check_eq("done_timeout", 64'h0, 64'h1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            check_eq("done_not_with_busy", 64'(bus.busy), 64'h0);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 64'h1, 64'h0);
            end else begin
                sb_exp = sb_q.pop_front();
                check_eq("sb_product", {bus.hi, bus.lo}, sb_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.is_signed   = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.mthi        = 1'b0;
        bus.mtlo        = 1'b0;
        bus.wdata       = '0;
        bus.hilo_access = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hi", 64'(bus.hi), 64'h0);
        check_eq("rst_lo", 64'(bus.lo), 64'h0);
        check_eq("rst_busy", 64'(bus.busy), 64'h0);
        check_eq("rst_done", 64'(bus.done), 64'h0);
        check_eq("rst_stall", 64'(bus.stall), 64'h0);
        next_drive();
        rst_n = 1'b1;
        next_drive();

        // Unsigned 2^31 * 2, with latency and busy-length checks.
        issue(32'h8000_0000, 32'h2, 1'b0, 1'b1);
        wait_result(nb, nc);
        check_eq("u_busy_cycles", 64'(nb), 64'd33);
        check_eq("u_latency", 64'(nc), 64'd34);
        check_eq("u_hi", 64'(bus.hi), 64'h1);
        check_eq("u_lo", 64'(bus.lo), 64'h0);
        @(negedge clk);
        check_eq("done_one_cycle", 64'(bus.done), 64'h0);
        next_drive();

        // Signed most-negative operand.
        issue(32'h8000_0000, 32'h2, 1'b1, 1'b1);
        wait_result(nb, nc);
        check_eq("s_min_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check_eq("s_min_lo", 64'(bus.lo), 64'h0);
        next_drive();

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_result(nb, nc);
        check_eq("s_m1_hi", 64'(bus.hi), 64'h0);
        check_eq("s_m1_lo", 64'(bus.lo), 64'h1);
        next_drive();

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_result(nb, nc);
        check_eq("u_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check_eq("u_max_lo", 64'(bus.lo), 64'h1);
        exp_hi = 32'hFFFF_FFFE;
        exp_lo = 32'h1;
        next_drive();

        // Busy interlock: stall, ignored restart and ignored mthi.
        issue(32'h1234, 32'h5678, 1'b0, 1'b1);
        bus.hilo_access = 1'b1;
        @(negedge clk);
        check_eq("stall_on", 64'(bus.stall), 64'h1);
        next_drive();
        bus.hilo_access = 1'b0;
        @(negedge clk);
        check_eq("stall_off", 64'(bus.stall), 64'h0);
        repeat (3) next_drive();
        bus.op_a  = 32'hFFFF;
        bus.op_b  = 32'hFFFF;
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        next_drive();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        @(negedge clk);
        check_eq("calc_hold_hi", 64'(bus.hi), 64'(exp_hi));
        check_eq("calc_hold_lo", 64'(bus.lo), 64'(exp_lo));
        check_eq("calc_busy", 64'(bus.busy), 64'h1);
        wait_result(nb, nc);
        check_eq("ilk_product", {bus.hi, bus.lo}, model(32'h1234, 32'h5678, 1'b0));
        next_drive();

        // Moves while idle.
        bus.mthi  = 1'b1;
        bus.wdata = 32'h1234_5678;
        next_drive();
        bus.mthi = 1'b0;
        @(negedge clk);
        check_eq("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        check_eq("mthi_busy", 64'(bus.busy), 64'h0);
        check_eq("mthi_done", 64'(bus.done), 64'h0);
        next_drive();
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h9ABC_DEF0;
        next_drive();
        bus.mtlo = 1'b0;
        @(negedge clk);
        check_eq("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
        check_eq("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);
        check_eq("mtlo_busy", 64'(bus.busy), 64'h0);
        check_eq("mtlo_done", 64'(bus.done), 64'h0);
        next_drive();

        // Move and start in the same idle cycle.
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h55;
        issue(32'h3, 32'h5, 1'b0, 1'b1);
        bus.mtlo = 1'b0;
        @(negedge clk);
        check_eq("sim_lo_move", 64'(bus.lo), 64'h55);
        check_eq("sim_hi_kept", 64'(bus.hi), 64'h1234_5678);
        wait_result(nb, nc);
        check_eq("sim_hi", 64'(bus.hi), 64'h0);
        check_eq("sim_lo", 64'(bus.lo), 64'd15);
        next_drive();

        // Reset in the middle of a multiply.
        issue(32'h7, 32'h9, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(bus.busy), 64'h0);
        check_eq("mid_rst_done", 64'(bus.done), 64'h0);
        check_eq("mid_rst_hi", 64'(bus.hi), 64'h0);
        check_eq("mid_rst_lo", 64'(bus.lo), 64'h0);
        next_drive();
        rst_n = 1'b1;
        next_drive();
        issue(32'h7, 32'h9, 1'b0, 1'b1);
        wait_result(nb, nc);
        check_eq("post_rst_lo", 64'(bus.lo), 64'd63);
        check_eq("post_rst_hi", 64'(bus.hi), 64'h0);
        next_drive();

        check_eq("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
